// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader and the instruction memory it feeds.
// Holds the loader state encoding, memory geometry and byte-lane positions.
package prog_loader_pkg;

    localparam int INST_W  = 25;
    localparam int IMEM_AW = 8;

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_ADDR  = 4'd1,
        S_CNT   = 4'd2,
        S_B0    = 4'd3,
        S_B1    = 4'd4,
        S_B2    = 4'd5,
        S_B3    = 4'd6,
        S_WRITE = 4'd7,
        S_CSUM  = 4'd8
    } state_t;

    typedef enum logic [1:0] {
        POS_B0 = 2'd0,
        POS_B1 = 2'd1,
        POS_B2 = 2'd2,
        POS_B3 = 2'd3
    } byte_pos_t;

    // A count byte of zero encodes a full 256-word frame.
    function automatic logic [8:0] word_count(input logic [7:0] n);
        return (n == 8'd0) ? 9'd256 : {1'b0, n};
    endfunction

endpackage

// File: rtl/prog_loader_word_asm.sv
// Assembles one 25-bit instruction word from four little-endian bytes.
// The word is presented combinationally while the final byte is on the bus.
module prog_loader_word_asm
    import prog_loader_pkg::*;
(
    input  logic              clk,
    input  logic              Reset,
    input  logic              load,
    input  byte_pos_t         pos,
    input  logic [7:0]        data,
    output logic [INST_W-1:0] word,
    output logic              b3_bad
);

    logic [23:0] low;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            low <= '0;
        end else if (load && pos != POS_B3) begin
            low <= {data, low[23:8]};
        end
    end

    // Only bit 0 of the last byte carries instruction data.
    assign word   = {data[0], low};
    assign b3_bad = |data[7:1];

endmodule

// File: rtl/prog_loader.sv
// Framed byte-stream loader that writes instruction memory and holds the core
// stalled while a program is being transferred.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE     = 8'hA5,
    parameter bit         HOLD_AT_RESET = 1'b1
) (
    input  logic               clk,
    input  logic               Reset,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    output logic               rx_ready,
    output logic               imem_we,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic [INST_W-1:0]  imem_wdata,
    output logic               cpu_hold,
    output logic               busy,
    output logic               load_done,
    output logic               load_err
);

    state_t            state;
    logic [8:0]        words_left;
    logic [7:0]        csum;
    logic              take;
    logic              asm_load;
    byte_pos_t         asm_pos;
    logic [INST_W-1:0] asm_word;
    logic              b3_bad;

    assign take     = rx_valid && rx_ready;
    assign asm_load = take && (state inside {S_B0, S_B1, S_B2, S_B3});

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        asm_pos = POS_B0;
        case (state)
            S_B1:    asm_pos = POS_B1;
            S_B2:    asm_pos = POS_B2;
            S_B3:    asm_pos = POS_B3;
            default: asm_pos = POS_B0;
        endcase
    end

    prog_loader_word_asm u_word_asm (
        .clk    (clk),
        .Reset  (Reset),
        .load   (asm_load),
        .pos    (asm_pos),
        .data   (rx_data),
        .word   (asm_word),
        .b3_bad (b3_bad)
    );

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state      <= S_IDLE;
            words_left <= '0;
            csum       <= '0;
            rx_ready   <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            cpu_hold   <= HOLD_AT_RESET;
            busy       <= 1'b0;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
        end else begin
            // Strobes default low and the link defaults open; states override.
            rx_ready  <= 1'b1;
            imem_we   <= 1'b0;
            load_done <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (take && rx_data == SYNC_BYTE) begin
                        state    <= S_ADDR;
                        load_err <= 1'b0;
                        busy     <= 1'b1;
                        cpu_hold <= 1'b1;
                        csum     <= '0;
                    end
                end
                S_ADDR: begin
                    if (take) begin
                        imem_addr <= rx_data;
                        csum      <= csum + rx_data;
                        state     <= S_CNT;
                    end
                end
                S_CNT: begin
                    if (take) begin
                        words_left <= word_count(rx_data);
                        csum       <= csum + rx_data;
                        state      <= S_B0;
                    end
                end
                S_B0, S_B1, S_B2: begin
                    if (take) begin
                        csum  <= csum + rx_data;
                        state <= (state == S_B0) ? S_B1 :
                                 (state == S_B1) ? S_B2 : S_B3;
                    end
                end
                S_B3: begin
                    if (take) begin
                        csum <= csum + rx_data;
                        if (b3_bad) begin
                            load_err <= 1'b1;
                            busy     <= 1'b0;
                            state    <= S_IDLE;
                        end else begin
                            imem_we    <= 1'b1;
                            imem_wdata <= asm_word;
                            rx_ready   <= 1'b0;
                            state      <= S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    imem_addr  <= imem_addr + 8'd1;
                    words_left <= words_left - 9'd1;
                    state      <= (words_left == 9'd1) ? S_CSUM : S_B0;
                end
                S_CSUM: begin
                    if (take) begin
                        if (rx_data == csum) begin
                            load_done <= 1'b1;
                            cpu_hold  <= 1'b0;
                        end else begin
                            load_err <= 1'b1;
                        end
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader: framing, wrap, errors,
// backpressure with gaps, full 256-word frame and reset mid-frame.
module tb_prog_loader;
    import prog_loader_pkg::*;

    logic               clk = 1'b0;
    logic               Reset = 1'b0;
    logic [7:0]         rx_data = 8'h00;
    logic               rx_valid = 1'b0;
    logic               rx_ready;
    logic               imem_we;
    logic [IMEM_AW-1:0] imem_addr;
    logic [INST_W-1:0]  imem_wdata;
    logic               cpu_hold;
    logic               busy;
    logic               load_done;
    logic               load_err;

    prog_loader #(.SYNC_BYTE(8'hA5), .HOLD_AT_RESET(1'b1)) dut (
        .clk        (clk),
        .Reset      (Reset),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .load_done  (load_done),
        .load_err   (load_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Write/handshake monitor, sampled on the falling edge.
    bit          mon_en = 1'b0;
    int unsigned cap_addr[$];
    int unsigned cap_data[$];
    int          done_cnt = 0;
    int          ready_viol = 0;
    int          done_hold_bad = 0;

    always @(negedge clk) begin
        if (mon_en && Reset) begin
            if (imem_we) begin
                cap_addr.push_back(32'(imem_addr));
                cap_data.push_back(32'(imem_wdata));
            end
            if (load_done) begin
                done_cnt++;
                if (cpu_hold) done_hold_bad++;
            end
            if (rx_ready == imem_we) ready_viol++;
        end
    end

    task automatic clear_mon();
        cap_addr.delete();
        cap_data.delete();
        done_cnt      = 0;
        ready_viol    = 0;
        done_hold_bad = 0;
    endtask

    bit gaps = 1'b0;

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!rx_ready) begin
            check("rx_ready_timeout", 32'(rx_ready), 32'd1);
            rx_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 rx_valid = 1'b0;
    endtask

    function automatic logic [24:0] wpat(input logic [24:0] base, input logic [24:0] step, input int j);
        logic [31:0] t;
        t = 32'(base) + 32'(step) * 32'(j);
        return t[24:0];
    endfunction

    task automatic send_frame(input logic [7:0] a, input logic [7:0] n,
                              input logic [24:0] base, input logic [24:0] step,
                              input logic [7:0] delta);
        logic [7:0]  cs;
        logic [24:0] w;
        int          nw;
        nw = (n == 8'd0) ? 256 : int'(n);
        cs = a + n;
        send_byte(8'hA5);
        check("sync_hold", 32'(cpu_hold), 32'd1);
        check("sync_busy", 32'(busy), 32'd1);
        send_byte(a);
        send_byte(n);
        for (int j = 0; j < nw; j++) begin
            w = wpat(base, step, j);
            cs = cs + w[7:0] + w[15:8] + w[23:16] + {7'b0, w[24]};
            send_byte(w[7:0]);
            send_byte(w[15:8]);
            send_byte(w[23:16]);
            send_byte({7'b0, w[24]});
        end
        send_byte(cs + delta);
        repeat (2) @(negedge clk);
    endtask

    task automatic exp_write(input string tag, input int idx, input logic [7:0] a, input logic [24:0] d);
        if (idx < cap_addr.size()) begin
            check({tag, "_addr"}, cap_addr[idx], 32'(a));
            check({tag, "_data"}, cap_data[idx], 32'(d));
        end else begin
            check({tag, "_missing"}, cap_addr.size(), 32'(idx + 1));
        end
    endtask

    task automatic check_status(input string tag, input int ndone, input logic err, input logic hold);
        check({tag, "_done"}, done_cnt, ndone);
        check({tag, "_err"}, 32'(load_err), 32'(err));
        check({tag, "_hold"}, 32'(cpu_hold), 32'(hold));
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_ready_viol"}, ready_viol, 0);
        check({tag, "_done_hold"}, done_hold_bad, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values.
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(rx_ready), 32'd0);
        check("rst_we", 32'(imem_we), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(load_done), 32'd0);
        check("rst_err", 32'(load_err), 32'd0);
        check("rst_addr", 32'(imem_addr), 32'd0);
        check("rst_wdata", 32'(imem_wdata), 32'd0);
        check("rst_hold", 32'(cpu_hold), 32'd1);
        Reset = 1'b1;
        @(posedge clk);
        #1 check("rel_ready", 32'(rx_ready), 32'd1);
        mon_en = 1'b1;

        // Basic frame.
        clear_mon();
        send_frame(8'h10, 8'h02, 25'h0123456, 25'h1999999, 8'h00);
        check("basic_count", cap_addr.size(), 32'd2);
        exp_write("basic_w0", 0, 8'h10, 25'h0123456);
        exp_write("basic_w1", 1, 8'h11, 25'h1ABCDEF);
        check_status("basic", 1, 1'b0, 1'b0);

        // Address wrap.
        clear_mon();
        send_frame(8'hFF, 8'h03, 25'h1000001, 25'h00F0F0F, 8'h00);
        check("wrap_count", cap_addr.size(), 32'd3);
        exp_write("wrap_w0", 0, 8'hFF, 25'h1000001);
        exp_write("wrap_w1", 1, 8'h00, 25'h10F0F10);
        exp_write("wrap_w2", 2, 8'h01, 25'h11E1E1F);
        check_status("wrap", 1, 1'b0, 1'b0);

        // Bad checksum, then recovery.
        clear_mon();
        send_frame(8'h40, 8'h02, 25'h00000AA, 25'h0000001, 8'h01);
        check("badcs_count", cap_addr.size(), 32'd2);
        exp_write("badcs_w0", 0, 8'h40, 25'h00000AA);
        exp_write("badcs_w1", 1, 8'h41, 25'h00000AB);
        check_status("badcs", 0, 1'b1, 1'b1);
        clear_mon();
        send_frame(8'h50, 8'h01, 25'h1FFFFFF, 25'h0000000, 8'h00);
        exp_write("recov_w0", 0, 8'h50, 25'h1FFFFFF);
        check_status("recov", 1, 1'b0, 1'b0);

        // Illegal b3; trailing bytes ignored until the next sync.
        clear_mon();
        send_byte(8'hA5);
        send_byte(8'h20);
        send_byte(8'h02);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h03);
        @(negedge clk);
        check("b3_err", 32'(load_err), 32'd1);
        check("b3_busy", 32'(busy), 32'd0);
        check("b3_writes", cap_addr.size(), 32'd0);
        send_byte(8'h44);
        send_byte(8'h55);
        send_byte(8'h66);
        send_byte(8'h00);
        send_byte(8'h12);
        repeat (2) @(negedge clk);
        check("b3_tail_writes", cap_addr.size(), 32'd0);
        check_status("b3_tail", 0, 1'b1, 1'b1);
        clear_mon();
        send_frame(8'h30, 8'h01, 25'h1A5A5A5, 25'h0000000, 8'h00);
        exp_write("b3_recov_w0", 0, 8'h30, 25'h1A5A5A5);
        check_status("b3_recov", 1, 1'b0, 1'b0);

        // Backpressure with random gaps.
        clear_mon();
        gaps = 1'b1;
        send_frame(8'h10, 8'h02, 25'h0123456, 25'h1999999, 8'h00);
        gaps = 1'b0;
        check("gap_count", cap_addr.size(), 32'd2);
        exp_write("gap_w0", 0, 8'h10, 25'h0123456);
        exp_write("gap_w1", 1, 8'h11, 25'h1ABCDEF);
        check_status("gap", 1, 1'b0, 1'b0);

        // N = 0 means 256 words.
        clear_mon();
        send_frame(8'h00, 8'h00, 25'h0000000, 25'h0010001, 8'h00);
        check("n0_count", cap_addr.size(), 32'd256);
        exp_write("n0_w0", 0, 8'h00, 25'h0000000);
        exp_write("n0_w128", 128, 8'h80, 25'h0800080);
        exp_write("n0_w255", 255, 8'hFF, 25'h0FF00FF);
        check_status("n0", 1, 1'b0, 1'b0);

        // Reset mid-frame after b1 of the second word.
        clear_mon();
        send_byte(8'hA5);
        send_byte(8'h60);
        send_byte(8'h03);
        send_byte(8'h45);
        send_byte(8'h23);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h99);
        send_byte(8'h88);
        @(negedge clk);
        Reset = 1'b0;
        #1;
        check("mid_ready", 32'(rx_ready), 32'd0);
        check("mid_we", 32'(imem_we), 32'd0);
        check("mid_busy", 32'(busy), 32'd0);
        check("mid_done", 32'(load_done), 32'd0);
        check("mid_err", 32'(load_err), 32'd0);
        check("mid_addr", 32'(imem_addr), 32'd0);
        check("mid_wdata", 32'(imem_wdata), 32'd0);
        check("mid_hold", 32'(cpu_hold), 32'd1);
        check("mid_count", cap_addr.size(), 32'd1);
        exp_write("mid_w0", 0, 8'h60, 25'h0012345);
        repeat (3) @(negedge clk);
        Reset = 1'b1;
        repeat (3) @(negedge clk);
        check("mid_after_count", cap_addr.size(), 32'd1);
        check("mid_after_busy", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
# prog_loader

Byte-stream program loader: the write side of the processor's instruction memory, which the core only reads. It accepts framed bytes from a host link, assembles them into 25-bit instruction words and writes them to consecutive instruction-memory addresses. While loading it holds the core stalled through `cpu_hold`. It sits beside `Instruction_Memory` at the processor top level.

## Interface
Parameters:
- `SYNC_BYTE`, 8'hA5, frame start marker.
- `HOLD_AT_RESET`, 1, reset value of `cpu_hold`.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `Reset`  in  1  reset, asynchronous, active-low; clears all state.
- `rx_data`  in  8  incoming byte.
- `rx_valid`  in  1  `rx_data` is valid.
- `rx_ready`  out  1  loader accepts the byte this cycle.
- `imem_we`  out  1  instruction-memory write strobe, one cycle per word.
- `imem_addr`  out  8  write address.
- `imem_wdata`  out  25  instruction word: {opcode[4:0], fields[19:0]}.
- `cpu_hold`  out  1  stalls the PC and timing generator.
- `busy`  out  1  frame in progress.
- `load_done`  out  1  one-cycle pulse on a successful frame.
- `load_err`  out  1  sticky error flag; cleared at the next accepted `SYNC_BYTE`.

## Operation
- A byte is accepted on any cycle where `rx_valid && rx_ready` at the clock edge.
- Frame layout: `SYNC_BYTE`, start address A, count N, then 4·N payload bytes, then a checksum byte.
  - N = 0 means 256 words.
  - Each word arrives little-endian in 4 bytes: b0 = wdata[7:0], b1 = [15:8], b2 = [23:16], b3 = {7'b0, wdata[24]}.
- FSM states: IDLE, ADDR, CNT, B0, B1, B2, B3, WRITE, CSUM.
  - IDLE: discards every byte except `SYNC_BYTE`. On `SYNC_BYTE`: go to ADDR, clear `load_err`, set `busy` and `cpu_hold`.
  - ADDR: latch A into the address counter.
  - CNT: latch N into the word counter.
  - B0–B2: shift bytes into the word register.
  - B3: if b3[7:1] ≠ 0, set `load_err`, clear `busy`, return to IDLE (no write). Otherwise go to WRITE.
  - WRITE: one cycle with `rx_ready` = 0.
    - `imem_we` = 1 with the assembled word and the current address.
    - Then the address increments modulo 256 and the word counter decrements.
    - Next state: B0 if words remain, else CSUM.
  - CSUM: the received byte is compared with the running checksum.
    - Match: pulse `load_done`, clear `cpu_hold` and `busy`.
    - Mismatch: set `load_err`; `cpu_hold` stays 1.
    - Either way, return to IDLE.
- Running checksum: 8-bit sum, modulo 256, of the A, N and payload bytes (`SYNC_BYTE` and the checksum byte excluded). Reset to 0 on `SYNC_BYTE`.
- Address wrap: 8'hFF + 1 → 8'h00. Writes continue at 0 without error.
- Words written before a checksum failure remain in memory. After a failure `cpu_hold` stays 1 until a later frame succeeds.
- A `SYNC_BYTE` value arriving inside a frame is treated as data; there is no resync mid-frame.

## Timing
- Reset values:
  - `rx_ready`: 0 while `Reset` is low, 1 in the first cycle after release.
  - `imem_we`, `busy`, `load_done`, `load_err`: 0.
  - `imem_addr`, `imem_wdata`: 0.
  - `cpu_hold` = `HOLD_AT_RESET`.
- `rx_ready` = 1 in every state except WRITE.
- Write latency: `imem_we` rises in the cycle after the b3 handshake and lasts exactly 1 cycle. Address and data are stable in that cycle.
- Peak throughput: one word per 5 cycles.
- `cpu_hold` rises in the cycle after the `SYNC_BYTE` handshake. It falls in the same cycle that `load_done` pulses, i.e. the cycle after the checksum handshake.
- Reset asserted mid-frame: immediate return to the reset values. Any partial word is dropped and no write occurs.

## Structure
- A shared package holds:
  - state encoding constants (9 states, 4-bit);
  - `INST_W` = 25, `IMEM_AW` = 8;
  - the byte-position constants.
  The processor top and the instruction memory reuse `INST_W` and `IMEM_AW` from it.
- One natural sub-module: `prog_loader_word_asm`, a 4-byte shift/assemble register with a b3 upper-bit check. The FSM and counters stay in `prog_loader`.

## Test plan
- **Basic frame:** A5, 10, 02, words 0x0123456 and 0x1ABCDEF, correct checksum → two `imem_we` pulses, addr 0x10 then 0x11, with those data; `load_done` pulse; `cpu_hold` falls.
- **Wrap-around:** A = FF, N = 3 → writes to FF, 00, 01; `load_done` pulses.
- **Bad checksum:** checksum off by one → all writes still occur; `load_err` = 1; `cpu_hold` stays 1. The next good frame clears `load_err` and releases the hold.
- **Illegal b3:** b3 = 0x03 → `load_err` = 1, no write, FSM in IDLE. Payload bytes that follow are ignored until the next A5.
- **Backpressure and gaps:** random `rx_valid` gaps → `rx_ready` low exactly during the WRITE cycles; no bytes lost; data identical to the gapless run.
- **Reset mid-frame:** `Reset` low after b1 of word 2 → one write only, all outputs at reset values, `cpu_hold` = `HOLD_AT_RESET`.
